// File: rtl/aes_enc_core_pkg.sv
// Shared AES types, tables and round/key-schedule functions for the iterative encryption core.
// Byte k of a 128-bit block lives at bits [127-8k -: 8]; bytes are column-major (row k%4, column k/4).
package aes_enc_core_pkg;

  typedef enum logic [1:0] {RESET, MIDDLE, READY} states_t;

  localparam logic [2047:0] S_BOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [79:0] RCON = 80'h01020408102040801b36;

  function automatic int NkOf(input int key_bits);
    return key_bits / 32;
  endfunction

  function automatic int NrOf(input int key_bits);
    return key_bits / 32 + 6;
  endfunction

  function automatic logic [7:0] SBox(input logic [7:0] b);
    return S_BOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [31:0] SubWord(input logic [31:0] w);
    return {SBox(w[31:24]), SBox(w[23:16]), SBox(w[15:8]), SBox(w[7:0])};
  endfunction

  function automatic logic [31:0] RotWord(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Produces w[i] from w[i-Nk] and w[i-1]; rcon is zero outside its 10-entry table.
  function automatic logic [31:0] NextKeyWord(input logic [31:0] prev_nk_word,
                                              input logic [31:0] prev_word,
                                              input logic [6:0] i, input int nk);
    int ii;
    logic [7:0] rc;
    logic [31:0] temp;
    ii = int'(i);
    rc = 8'h00;
    if (ii / nk >= 1 && ii / nk <= 10) rc = RCON[79 - 8*(ii/nk - 1) -: 8];
    if (ii % nk == 0)                 temp = SubWord(RotWord(prev_word)) ^ {rc, 24'h0};
    else if (nk == 8 && ii % nk == 4) temp = SubWord(prev_word);
    else                              temp = prev_word;
    return prev_nk_word ^ temp;
  endfunction

  function automatic logic [127:0] SubBytes(input logic [127:0] s);
    logic [127:0] o;
    for (int k = 0; k < 16; k++) o[127 - 8*k -: 8] = SBox(s[127 - 8*k -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] ShiftRows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + r) % 4)) -: 8];
    return o;
  endfunction

  function automatic logic [7:0] XTime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] MixColumns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        a0 = s[127 - 8*(4*c + r) -: 8];
        a1 = s[127 - 8*(4*c + (r + 1) % 4) -: 8];
        a2 = s[127 - 8*(4*c + (r + 2) % 4) -: 8];
        a3 = s[127 - 8*(4*c + (r + 3) % 4) -: 8];
        o[127 - 8*(4*c + r) -: 8] = XTime(a0) ^ XTime(a1) ^ a1 ^ a2 ^ a3;
      end
    return o;
  endfunction

  function automatic logic [127:0] AddRoundKey(input logic [127:0] s, input logic [127:0] k);
    return s ^ k;
  endfunction

  function automatic logic [127:0] MidRound(input logic [127:0] s, input logic [127:0] k);
    return AddRoundKey(MixColumns(ShiftRows(SubBytes(s))), k);
  endfunction

  function automatic logic [127:0] FinalRound(input logic [127:0] s, input logic [127:0] k);
    return AddRoundKey(ShiftRows(SubBytes(s)), k);
  endfunction

endpackage

// File: rtl/aes_enc_core_key_sched.sv
// On-the-fly AES key expansion for Nk = 4/6/8 delivering one 4-word round key per cycle.
// The window always holds w[4r .. 4r+Nk-1]; the Nk-4 words past the current round key are the lookahead buffer.
module aes_key_sched
  import aes_enc_core_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [0:KEY_BITS-1]   key,
  input  logic                  advance,
  output logic [0:127]          round_key
);

  localparam int NK = NkOf(KEY_BITS);

  logic [31:0] win_q [NK];
  logic [31:0] win_d [NK];
  logic [31:0] next_win [NK];
  logic [31:0] gen_w [4];
  logic [6:0]  idx_q, idx_d;

  // Four chained expansion steps produce w[idx .. idx+3].
  always_comb begin
    logic [31:0] prev;
    prev = win_q[NK-1];
    for (int k = 0; k < 4; k++) begin
      gen_w[k] = NextKeyWord(win_q[k], prev, idx_q + 7'(k), NK);
      prev     = gen_w[k];
    end
  end

  for (genvar gi = 0; gi < NK; gi++) begin : g_next_win
    if (gi < NK - 4) begin : g_keep
      assign next_win[gi] = win_q[gi + 4];
    end else begin : g_new
      assign next_win[gi] = gen_w[gi - (NK - 4)];
    end
  end

  // While loading, w[0..3] comes straight from the key; otherwise the key for the round about to run.
  always_comb begin
    if (load) round_key = key[0:127];
    else      round_key = {next_win[0], next_win[1], next_win[2], next_win[3]};
  end

  always_comb begin
    win_d = win_q;
    idx_d = idx_q;
    if (load) begin
      for (int j = 0; j < NK; j++) win_d[j] = key[32*j +: 32];
      idx_d = 7'(NK);
    end else if (advance) begin
      win_d = next_win;
      idx_d = idx_q + 7'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j < NK; j++) win_q[j] <= '0;
      idx_q <= '0;
    end else begin
      win_q <= win_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/aes_enc_core.sv
// Iterative AES encryption core: one round per clock, on-the-fly key schedule, valid/ready in and out.
module aes_enc_core
  import aes_enc_core_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [0:127]        in_data,
  input  logic [0:KEY_BITS-1] in_key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [0:127]        out_data
);

  localparam int NR = NrOf(KEY_BITS);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_enc_core: KEY_BITS must be 128, 192 or 256");
  end

  states_t      fsm_q, fsm_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] state_q, state_d;
  logic [127:0] out_data_q, out_data_d;
  logic         out_valid_q, out_valid_d;
  logic         accept;
  logic [0:127] round_key;
  logic [127:0] rk;

  assign in_ready  = rst_n && (fsm_q == RESET || (fsm_q == READY && out_ready));
  assign accept    = in_valid && in_ready;
  assign rk        = round_key;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  aes_key_sched #(.KEY_BITS(KEY_BITS)) u_key_sched (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .key       (in_key),
    .advance   (fsm_q == MIDDLE),
    .round_key (round_key)
  );

  always_comb begin
    fsm_d       = fsm_q;
    round_d     = round_q;
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (fsm_q)
      RESET: begin
        if (accept) begin
          state_d = in_data ^ rk;
          round_d = 4'd1;
          fsm_d   = MIDDLE;
        end
      end
      MIDDLE: begin
        if (round_q == 4'(NR)) begin
          state_d     = FinalRound(state_q, rk);
          out_data_d  = FinalRound(state_q, rk);
          out_valid_d = 1'b1;
          round_d     = 4'd0;
          fsm_d       = READY;
        end else begin
          state_d = MidRound(state_q, rk);
          round_d = round_q + 4'd1;
        end
      end
      READY: begin
        // Draining and accepting in the same cycle keeps the pipeline at one block per NR+1 cycles.
        if (out_ready) begin
          out_valid_d = 1'b0;
          fsm_d       = RESET;
          if (accept) begin
            state_d = in_data ^ rk;
            round_d = 4'd1;
            fsm_d   = MIDDLE;
          end
        end
      end
      default: fsm_d = RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q       <= RESET;
      round_q     <= '0;
      state_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      round_q     <= round_d;
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_aes_enc_core.sv
// Bench for aes_enc_core at all three key sizes against FIPS-197 vectors and a byte-level reference model.
module tb_aes_enc_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         out_ready;
  logic [0:127] in_data;
  logic [0:255] key_bus;
  logic [2:0]   in_valid, in_ready, out_valid;
  logic [0:127] out_data0, out_data1, out_data2;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb [256];

  aes_enc_core #(.KEY_BITS(128)) u_dut128 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data), .in_key(key_bus[0:127]), .out_valid(out_valid[0]),
    .out_ready(out_ready), .out_data(out_data0));

  aes_enc_core #(.KEY_BITS(192)) u_dut192 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data), .in_key(key_bus[0:191]), .out_valid(out_valid[1]),
    .out_ready(out_ready), .out_data(out_data1));

  aes_enc_core #(.KEY_BITS(256)) u_dut256 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data), .in_key(key_bus), .out_valid(out_valid[2]),
    .out_ready(out_ready), .out_data(out_data2));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (GF(2^8) arithmetic, byte matrices) ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic hi;
    p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // S-box = affine transform of the multiplicative inverse.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic logic [127:0] ref_enc(input logic [127:0] pt, input logic [255:0] key, input int kbits);
    int nk, nr, d;
    logic [31:0] w [60];
    logic [7:0] s [4][4];
    logic [7:0] t [4][4];
    logic [7:0] rc, acc, coef;
    logic [31:0] tmp;
    logic [127:0] res;
    nk = kbits / 32;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr + 1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[r][c] = pt[127 - 8*(r + 4*c) -: 8] ^ w[c][31 - 8*r -: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r][c] = sb[s[(r)][(c + r) % 4]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          if (rnd < nr) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++) begin
              d    = (k - r + 4) % 4;
              coef = (d == 0) ? 8'h02 : (d == 1) ? 8'h03 : 8'h01;
              acc  = acc ^ gmul(coef, t[k][c]);
            end
          end else begin
            acc = t[r][c];
          end
          s[r][c] = acc ^ w[4*rnd + c][31 - 8*r -: 8];
        end
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) res[127 - 8*(r + 4*c) -: 8] = s[r][c];
    return res;
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic logic [127:0] get_out(input int sel);
    if (sel == 0) return out_data0;
    if (sel == 1) return out_data1;
    return out_data2;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Offers one block, then scrambles the data/key ports every cycle until out_valid appears.
  task automatic run_block(input int sel, input logic [127:0] pt, input logic [255:0] key,
                           input logic [127:0] exp, input string tag, output int waited);
    int cyc;
    bit seen;
    in_data       = pt;
    key_bus       = key;
    in_valid[sel] = 1'b1;
    #1;
    waited = 0;
    while (!in_ready[sel] && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_accept"}, 128'(in_ready[sel]), 128'd1);
    @(posedge clk);
    #1;
    in_valid[sel] = 1'b0;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      in_data = rand128();
      key_bus = {rand128(), rand128()};
      @(negedge clk);
      cyc++;
      if (out_valid[sel]) seen = 1'b1;
      else check({tag, "_busy_in_ready"}, 128'(in_ready[sel]), 128'd0);
    end
    check({tag, "_latency"}, 128'(cyc), 128'(13 + 2*sel - 2));
    check({tag, "_data"}, get_out(sel), exp);
    $display("block %s sel=%0d latency=%0d out=%h", tag, sel, cyc, get_out(sel));
  endtask

  // Holds the result for 'hold' cycles under backpressure, then drains it.
  task automatic drain(input int sel, input logic [127:0] exp, input int hold, input string tag);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 128'(out_valid[sel]), 128'd1);
      check({tag, "_hold_data"}, get_out(sel), exp);
      check({tag, "_hold_in_ready"}, 128'(in_ready[sel]), 128'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_drained"}, 128'(out_valid[sel]), 128'd0);
  endtask

  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY_C  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C2  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int waited, hold, sel, aborted_hits;
    logic [127:0] pt, exp;
    logic [255:0] key;

    build_sbox();
    rst_n     = 1'b0;
    out_ready = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    key_bus   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      check("rst_out_valid", 128'(out_valid[s]), 128'd0);
      check("rst_out_data", get_out(s), 128'd0);
      check("rst_in_ready", 128'(in_ready[s]), 128'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 3; s++) check("idle_in_ready", 128'(in_ready[s]), 128'd1);

    // Published vectors at each key size.
    run_block(0, PT_B, KEY_B, CT_B, "fips128", waited);
    drain(0, CT_B, 0, "fips128");
    run_block(1, PT_C, KEY_C, CT_C2, "fips192", waited);
    drain(1, CT_C2, 0, "fips192");
    run_block(2, PT_C, KEY_C, CT_C3, "fips256", waited);
    drain(2, CT_C3, 0, "fips256");

    // Backpressure for 20 cycles, then drain and accept the next block in the same cycle.
    out_ready = 1'b0;
    run_block(0, PT_C, KEY_C, CT_C1, "bp", waited);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("bp_hold_data", get_out(0), CT_C1);
      check("bp_hold_valid", 128'(out_valid[0]), 128'd1);
      check("bp_hold_in_ready", 128'(in_ready[0]), 128'd0);
    end
    out_ready = 1'b1;
    run_block(0, PT_B, KEY_B, CT_B, "b2b", waited);
    check("b2b_same_cycle", 128'(waited), 128'd0);
    drain(0, CT_B, 0, "b2b");

    // Reset during round 5 must abort the block without any output.
    in_data     = rand128();
    key_bus     = {rand128(), rand128()};
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("abort_out_valid", 128'(out_valid[0]), 128'd0);
    check("abort_in_ready", 128'(in_ready[0]), 128'd1);
    aborted_hits = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (out_valid[0]) aborted_hits++;
    end
    check("abort_no_output", 128'(aborted_hits), 128'd0);
    pt  = rand128();
    key = {rand128(), rand128()};
    exp = ref_enc(pt, key, 128);
    run_block(0, pt, key, exp, "post_abort", waited);
    drain(0, exp, 0, "post_abort");

    // Random blocks at all key sizes with random backpressure.
    for (int it = 0; it < 9; it++) begin
      sel  = it % 3;
      pt   = rand128();
      key  = {rand128(), rand128()};
      exp  = ref_enc(pt, key, 128 + 64*sel);
      hold = int'($urandom_range(0, 3));
      out_ready = (hold == 0);
      run_block(sel, pt, key, exp, "rand", waited);
      drain(sel, exp, hold, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
